pll_lock_sequencer: RTL and testbench

//  Sequences the ECP5 EHXPLLL wrapper: pulses PLL reset, waits for LOCK, qualifies it as stable, then releases sys_ready.

---
 rtl/pll_seq_pkg.sv | 20 ++
 rtl/bit_sync.sv | 21 ++
 rtl/pll_lock_sequencer.sv | 126 ++++++++++++
 tb/tb_pll_lock_sequencer.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pll_seq_pkg.sv
// Shared types and constants for the PLL lock sequencer.
package pll_seq_pkg;

    typedef enum logic [2:0] {
        RST_PLL   = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RUN       = 3'd3,
        FAULT     = 3'd4
    } state_t;

    localparam int LOSS_CNT_W = 8;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/bit_sync.sv
// Two-flop synchroniser for a single asynchronous level; resets to 0.
module bit_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_lock_sequencer.sv
// Resets the PLL, qualifies LOCK as stable, releases sys_ready, and retries or
// faults when the PLL fails to lock. Runs on the free-running board clock.
module pll_lock_sequencer
    import pll_seq_pkg::*;
#(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 65536,
    parameter int STABLE_CYCLES = 1024,
    parameter int MAX_RETRIES   = 3,
    parameter int BYPASS        = 0
) (
    input  logic                  clock_in,
    input  logic                  reset_n,
    input  logic                  pll_locked,
    input  logic                  restart,
    output logic                  pll_rst,
    output logic                  sys_ready,
    output logic                  fault,
    output logic [2:0]            state_o,
    output logic [LOSS_CNT_W-1:0] lock_loss_count
);

    localparam int TIMER_MAX = max3(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
    localparam int TW        = $clog2(TIMER_MAX + 1);
    localparam int RW        = $clog2(MAX_RETRIES + 2);

    localparam logic [TW-1:0] RST_LAST     = TW'(RST_CYCLES - 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(LOCK_TIMEOUT - 1);
    localparam logic [TW-1:0] STABLE_LAST  = TW'(STABLE_CYCLES - 1);
    localparam logic [RW-1:0] RETRY_LIMIT  = RW'(MAX_RETRIES);

    state_t                state, state_nxt;
    logic [TW-1:0]         timer, timer_nxt;
    logic [RW-1:0]         retries, retries_nxt;
    logic [LOSS_CNT_W-1:0] loss_cnt_nxt;
    logic                  lock_s;
    logic                  retry;

    bit_sync u_lock_sync (
        .clk   (clock_in),
        .rst_n (reset_n),
        .d     (pll_locked),
        .q     (lock_s)
    );

    always_comb begin
        state_nxt    = state;
        retries_nxt  = retries;
        loss_cnt_nxt = lock_loss_count;
        retry        = 1'b0;

        case (state)
            RST_PLL: begin
                if (timer == RST_LAST) state_nxt = WAIT_LOCK;
            end
            WAIT_LOCK: begin
                // A lock arriving on the timeout cycle still counts as a lock.
                if (lock_s)                     state_nxt = STABLE;
                else if (timer == TIMEOUT_LAST) retry = 1'b1;
            end
            STABLE: begin
                if (!lock_s) begin
                    retry = 1'b1;
                end else if (timer == STABLE_LAST) begin
                    state_nxt   = RUN;
                    retries_nxt = '0;
                end
            end
            RUN: begin
                if (!lock_s) begin
                    state_nxt = RST_PLL;
                    if (lock_loss_count != '1) loss_cnt_nxt = lock_loss_count + 1'b1;
                end
            end
            FAULT:   state_nxt = FAULT;
            default: state_nxt = RST_PLL;
        endcase

        if (retry) begin
            retries_nxt = retries + 1'b1;
            state_nxt   = (retries_nxt > RETRY_LIMIT) ? FAULT : RST_PLL;
        end

        // Restart overrides the transition but a lock drop seen in RUN stays counted.
        if (restart) begin
            state_nxt   = RST_PLL;
            retries_nxt = '0;
        end

        if (BYPASS != 0) begin
            state_nxt    = RUN;
            retries_nxt  = '0;
            loss_cnt_nxt = '0;
        end

        if (state_nxt != state || restart)
            timer_nxt = '0;
        else if (state == RST_PLL || state == WAIT_LOCK || state == STABLE)
            timer_nxt = timer + 1'b1;
        else
            timer_nxt = '0;
    end

    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            state           <= RST_PLL;
            timer           <= '0;
            retries         <= '0;
            lock_loss_count <= '0;
            pll_rst         <= 1'b1;
            sys_ready       <= 1'b0;
            fault           <= 1'b0;
        end else begin
            state           <= state_nxt;
            timer           <= timer_nxt;
            retries         <= retries_nxt;
            lock_loss_count <= loss_cnt_nxt;
            pll_rst         <= (state_nxt == RST_PLL) || (state_nxt == FAULT);
            sys_ready       <= (state_nxt == RUN);
            fault           <= (state_nxt == FAULT);
        end
    end

    assign state_o = state;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed bench for pll_lock_sequencer, plus a second instance built with BYPASS=1.
module tb_pll_lock_sequencer;

    localparam logic [2:0] S_RST    = 3'd0;
    localparam logic [2:0] S_WAIT   = 3'd1;
    localparam logic [2:0] S_STABLE = 3'd2;
    localparam logic [2:0] S_RUN    = 3'd3;
    localparam logic [2:0] S_FAULT  = 3'd4;

    logic       clk = 1'b0;
    logic       reset_n, pll_locked, restart;
    logic       pll_rst, sys_ready, fault;
    logic [2:0] state_o;
    logic [7:0] lock_loss_count;

    logic       b_reset_n, b_locked, b_restart;
    logic       b_pll_rst, b_sys_ready, b_fault;
    logic [2:0] b_state;
    logic [7:0] b_count;

    int tests_run    = 0;
    int tests_failed = 0;

    always #20 clk = ~clk;

    pll_lock_sequencer #(
        .RST_CYCLES(4), .LOCK_TIMEOUT(20), .STABLE_CYCLES(8), .MAX_RETRIES(2), .BYPASS(0)
    ) dut (
        .clock_in        (clk),
        .reset_n         (reset_n),
        .pll_locked      (pll_locked),
        .restart         (restart),
        .pll_rst         (pll_rst),
        .sys_ready       (sys_ready),
        .fault           (fault),
        .state_o         (state_o),
        .lock_loss_count (lock_loss_count)
    );

    pll_lock_sequencer #(
        .RST_CYCLES(4), .LOCK_TIMEOUT(20), .STABLE_CYCLES(8), .MAX_RETRIES(2), .BYPASS(1)
    ) dut_bypass (
        .clock_in        (clk),
        .reset_n         (b_reset_n),
        .pll_locked      (b_locked),
        .restart         (b_restart),
        .pll_rst         (b_pll_rst),
        .sys_ready       (b_sys_ready),
        .fault           (b_fault),
        .state_o         (b_state),
        .lock_loss_count (b_count)
    );

    // Advance n clock edges; values are then sampled/driven 1 ns after the edge.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // After this returns, the next rising edge is edge 1 of the new sequence.
    task automatic apply_reset();
        reset_n    = 1'b0;
        pll_locked = 1'b0;
        restart    = 1'b0;
        step(2);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n    = 1'b0;
        pll_locked = 1'b0;
        restart    = 1'b0;
        step(2);
        tests_run++;
        if (state_o !== S_RST) begin
            tests_failed++; $display("FAIL reset_state got=%0d exp=%0d", state_o, S_RST);
        end
        tests_run++;
        if ({pll_rst, sys_ready, fault} !== 3'b100) begin
            tests_failed++; $display("FAIL reset_outputs got=%b exp=100", {pll_rst, sys_ready, fault});
        end
        tests_run++;
        if (lock_loss_count !== 8'd0) begin
            tests_failed++; $display("FAIL reset_count got=%0d exp=0", lock_loss_count);
        end
        reset_n = 1'b1;
    endtask

    // pll_rst t1..t3, WAIT at t4, lock driven after t10 -> lock_s t12, STABLE t13, RUN t21.
    task automatic test_lock_sequence();
        logic exp_rst, exp_ready;
        apply_reset();
        for (int k = 1; k <= 22; k++) begin
            step(1);
            exp_rst   = (k <= 3);
            exp_ready = (k >= 21);
            tests_run++;
            if (pll_rst !== exp_rst) begin
                tests_failed++; $display("FAIL seq_pll_rst t=%0d got=%b exp=%b", k, pll_rst, exp_rst);
            end
            tests_run++;
            if (sys_ready !== exp_ready) begin
                tests_failed++; $display("FAIL seq_sys_ready t=%0d got=%b exp=%b", k, sys_ready, exp_ready);
            end
            if (k == 13) begin
                tests_run++;
                if (state_o !== S_STABLE) begin
                    tests_failed++; $display("FAIL seq_stable_entry got=%0d exp=%0d", state_o, S_STABLE);
                end
            end
            if (k == 10) pll_locked = 1'b1;
        end
        tests_run++;
        if ({fault, lock_loss_count} !== 9'd0) begin
            tests_failed++; $display("FAIL seq_fault_count got=%b/%0d exp=0/0", fault, lock_loss_count);
        end
    endtask

    // No lock: pulses t1-3, t24-27, t48-51; FAULT at t72; restart seen at edge 76.
    task automatic test_fault_and_restart();
        logic exp_rst, exp_fault;
        apply_reset();
        for (int k = 1; k <= 100; k++) begin
            step(1);
            exp_rst = (k <= 3) || (k >= 24 && k <= 27) || (k >= 48 && k <= 51) ||
                      (k >= 72 && k <= 79) || (k == 100);
            exp_fault = (k >= 72 && k <= 75);
            tests_run++;
            if (pll_rst !== exp_rst) begin
                tests_failed++; $display("FAIL fault_pll_rst t=%0d got=%b exp=%b", k, pll_rst, exp_rst);
            end
            tests_run++;
            if (fault !== exp_fault || sys_ready !== 1'b0) begin
                tests_failed++;
                $display("FAIL fault_flag t=%0d got=%b/%b exp=%b/0", k, fault, sys_ready, exp_fault);
            end
            if (k == 72 || k == 76 || k == 100) begin
                tests_run++;
                if (state_o !== ((k == 72) ? S_FAULT : S_RST)) begin
                    tests_failed++; $display("FAIL fault_state t=%0d got=%0d", k, state_o);
                end
            end
            if (k == 75) restart = 1'b1;
            if (k == 76) restart = 1'b0;
        end
    endtask

    // Each 1-cycle drop: RST_PLL 3 edges later, RUN again 16 edges after the drop.
    task automatic test_lock_loss();
        int exp_cnt;
        apply_reset();
        pll_locked = 1'b1;
        step(13);
        tests_run++;
        if (state_o !== S_RUN) begin
            tests_failed++; $display("FAIL loss_initial_run got=%0d exp=%0d", state_o, S_RUN);
        end
        exp_cnt = 0;
        for (int i = 1; i <= 300; i++) begin
            pll_locked = 1'b0;
            step(1);
            pll_locked = 1'b1;
            step(1);
            tests_run++;
            if (sys_ready !== 1'b1) begin
                tests_failed++; $display("FAIL loss_ready_hold i=%0d got=%b exp=1", i, sys_ready);
            end
            step(1);
            exp_cnt = (exp_cnt < 255) ? exp_cnt + 1 : 255;
            tests_run++;
            if (sys_ready !== 1'b0 || pll_rst !== 1'b1 || lock_loss_count !== 8'(exp_cnt)) begin
                tests_failed++;
                $display("FAIL loss_drop i=%0d got=%b/%b/%0d exp=0/1/%0d",
                         i, sys_ready, pll_rst, lock_loss_count, exp_cnt);
            end
            step(13);
            tests_run++;
            if (state_o !== S_RUN) begin
                tests_failed++; $display("FAIL loss_rerun i=%0d got=%0d exp=%0d", i, state_o, S_RUN);
            end
        end
    endtask

    // STABLE t5..; glitch driven at t8 -> retry at t11, RUN t24. Then a permanent drop
    // shows retries were cleared: three timeouts (t51, t75, t99) are needed to fault.
    task automatic test_glitch_in_stable();
        apply_reset();
        pll_locked = 1'b1;
        for (int k = 1; k <= 99; k++) begin
            step(1);
            if (k <= 24) begin
                tests_run++;
                if (sys_ready !== (k >= 24)) begin
                    tests_failed++; $display("FAIL glitch_ready t=%0d got=%b", k, sys_ready);
                end
            end
            if (k == 10 || k == 11 || k == 75 || k == 99) begin
                tests_run++;
                if (state_o !== ((k == 10) ? S_STABLE : (k == 99) ? S_FAULT : S_RST)) begin
                    tests_failed++; $display("FAIL glitch_state t=%0d got=%0d", k, state_o);
                end
            end
            if (k == 27) begin
                tests_run++;
                if (lock_loss_count !== 8'd1) begin
                    tests_failed++; $display("FAIL glitch_count got=%0d exp=1", lock_loss_count);
                end
            end
            if (k == 8)  pll_locked = 1'b0;
            if (k == 9)  pll_locked = 1'b1;
            if (k == 24) pll_locked = 1'b0;
        end
    endtask

    task automatic test_restart_and_mid_reset();
        apply_reset();
        pll_locked = 1'b1;
        step(13);
        pll_locked = 1'b0;
        step(2);
        restart = 1'b1;
        step(1);
        restart = 1'b0;
        tests_run++;
        if (state_o !== S_RST || lock_loss_count !== 8'd1 || sys_ready !== 1'b0 || pll_rst !== 1'b1) begin
            tests_failed++;
            $display("FAIL restart_with_drop got=%0d/%0d/%b/%b exp=0/1/0/1",
                     state_o, lock_loss_count, sys_ready, pll_rst);
        end
        step(6);
        tests_run++;
        if (state_o !== S_WAIT) begin
            tests_failed++; $display("FAIL midreset_pre got=%0d exp=%0d", state_o, S_WAIT);
        end
        reset_n = 1'b0;
        #1;
        tests_run++;
        if (state_o !== S_RST || {pll_rst, sys_ready, fault} !== 3'b100 || lock_loss_count !== 8'd0) begin
            tests_failed++;
            $display("FAIL midreset_values got=%0d/%b/%0d exp=0/100/0",
                     state_o, {pll_rst, sys_ready, fault}, lock_loss_count);
        end
        step(2);
        reset_n = 1'b1;
        step(3);
        tests_run++;
        if (state_o !== S_RST) begin
            tests_failed++; $display("FAIL midreset_timer t=3 got=%0d exp=%0d", state_o, S_RST);
        end
        step(1);
        tests_run++;
        if (state_o !== S_WAIT) begin
            tests_failed++; $display("FAIL midreset_timer t=4 got=%0d exp=%0d", state_o, S_WAIT);
        end
    endtask

    task automatic test_bypass();
        b_reset_n = 1'b0;
        b_locked  = 1'b0;
        b_restart = 1'b0;
        step(2);
        b_reset_n = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            step(1);
            tests_run++;
            if ({b_sys_ready, b_pll_rst, b_fault} !== 3'b100 || b_state !== S_RUN || b_count !== 8'd0) begin
                tests_failed++;
                $display("FAIL bypass t=%0d got=%b/%0d/%0d exp=100/%0d/0",
                         k, {b_sys_ready, b_pll_rst, b_fault}, b_state, b_count, S_RUN);
            end
            b_locked  = ~b_locked;
            b_restart = (k % 3 == 0);
        end
    endtask

    initial begin
        b_reset_n = 1'b0;
        b_locked  = 1'b0;
        b_restart = 1'b0;
        test_reset();
        test_lock_sequence();
        test_fault_and_restart();
        test_lock_loss();
        test_glitch_in_stable();
        test_restart_and_mid_reset();
        test_bypass();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
